// File: rtl/avalon_mem_responder.sv
// ============================================================================
// avalon_mem_responder : Avalon-MM 16-bit word memory slave with pipelined
// fixed-latency reads, bounded outstanding reads and LFSR stall injection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module avalon_mem_responder #(
   parameter int         ADDR_W      = 16,
   parameter int         RD_LATENCY  = 3,
   parameter int         MAX_PENDING = 4,
   parameter logic [7:0] STALL_MASK  = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] address,
   input  logic [1:0]  byteenable,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        readdatavalid,
   output logic        waitrequest,
   output logic [3:0]  pending,
   output logic        proto_err
);

   localparam int         C_DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] C_MAX_PEND = 4'(MAX_PENDING);

   logic [15:0]           mem_q [C_DEPTH];
   logic [7:0]            lfsr_q, lfsr_d;
   logic [RD_LATENCY-1:0] vld_q, vld_d;
   logic [RD_LATENCY-1:0] acc_vec;
   logic [15:0]           dat_q [RD_LATENCY];
   logic [3:0]            pend_q, pend_d;
   logic                  perr_q, perr_d;
   logic                  stall;
   logic                  accept;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [ADDR_W-1:0]     waddr;

   generate
      if (ADDR_W < 32) begin : g_addr_unused
         logic unused_addr_bits;
         assign unused_addr_bits = ^address[31:ADDR_W];
      end
   endgenerate

   assign waddr = address[ADDR_W-1:0];

   // Handshake depends only on registered state (plus reset), never on the command inputs.
   always_comb begin
      lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      stall       = (STALL_MASK != 8'h00) && ((lfsr_q & STALL_MASK) == STALL_MASK);
      waitrequest = reset | stall | ((pend_q == C_MAX_PEND) & ~vld_q[RD_LATENCY-1]);
      accept      = chipselect & ~waitrequest & (~read_n | ~write_n);
      rd_acc      = accept & ~read_n;
      wr_acc      = accept & read_n & ~write_n;
      perr_d      = perr_q | (accept & ~read_n & ~write_n);
      pend_d      = pend_q + {3'b000, rd_acc} - {3'b000, vld_q[RD_LATENCY-1]};
      acc_vec     = '0;
      acc_vec[0]  = rd_acc;
      vld_d       = (vld_q << 1) | acc_vec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= 8'hA5;
         vld_q  <= '0;
         pend_q <= 4'd0;
         perr_q <= 1'b0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            dat_q[i] <= 16'h0000;
         end
      end else begin
         lfsr_q <= lfsr_d;
         vld_q  <= vld_d;
         pend_q <= pend_d;
         perr_q <= perr_d;
         if (rd_acc) begin
            dat_q[0] <= mem_q[waddr];
         end
         // Each stage only loads when a valid word moves in, so the last stage holds its value.
         for (int i = 1; i < RD_LATENCY; i++) begin
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         if (byteenable[1]) begin
            mem_q[waddr][15:8] <= writedata[15:8];
         end
         if (byteenable[0]) begin
            mem_q[waddr][7:0] <= writedata[7:0];
         end
      end
   end

   assign readdata      = dat_q[RD_LATENCY-1];
   assign readdatavalid = vld_q[RD_LATENCY-1];
   assign pending       = pend_q;
   assign proto_err     = perr_q;

endmodule

`default_nettype wire
